// File: rtl/friscv_pkg.sv
// Shared definitions for the FRiscV fetch stage.
package friscv_pkg;

    localparam int XLEN = 32;

    // Step size for sequential fetch.
    localparam int PC_INC = 4;

    // Next-PC select encoding.
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_HOLD   = 2'b11
    } pc_src_t;

endpackage

// File: rtl/friscv_pc.sv
// Program counter register for the IF stage.
// pc_out comes straight from the register, so no input reaches it combinationally.
// Reset is synchronous and takes priority over every select value.
module friscv_pc
    import friscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_src_in,
    input  logic [XLEN-1:0] imm_in,
    output logic [XLEN-1:0] pc_out
);

    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    pc_src_t         pc_src;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;

    assign pc_src = pc_src_t'(pc_src_in);

    // Next-PC selection; sums wrap modulo 2^XLEN and need no overflow flag.
    always_comb begin
        pc_next = pc_q;
        case (pc_src)
            PC_PLUS4:  pc_next = pc_q + INC;
            PC_BRANCH: pc_next = pc_q + imm_in;
            PC_JALR:   pc_next = {imm_in[XLEN-1:1], 1'b0};
            PC_HOLD:   pc_next = pc_q;
            default:   pc_next = pc_q;
        endcase
    end

    // PC register; rst_n is an active-high reset despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_friscv_pc.sv
// Self-checking bench for friscv_pc: directed scenarios plus randomized traffic
// compared against a simple arithmetic model of the next-PC rules.
module tb_friscv_pc;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_src_in;
    logic [31:0] imm_in;
    logic [31:0] pc_out;

    int          checks;
    int          errors;
    logic [31:0] exp_pc;
    logic        prev_rst;

    friscv_pc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_src_in (pc_src_in),
        .imm_in    (imm_in),
        .pc_out    (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember whether the last rising edge saw reset asserted.
    always @(posedge clk) prev_rst <= rst_n;

    // Whenever the previous edge was a reset edge, pc_out must read zero.
    always @(negedge clk) begin
        if (prev_rst === 1'b1) begin
            checks++;
            if (pc_out !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold_assert: pc_out=%h required=%h at %0t", pc_out, 32'h0, $time);
            end
        end
    end

    // Apply one cycle of stimulus, advance the reference model, and move to the next falling edge.
    task automatic drive_cycle(input logic r, input logic [1:0] s, input logic [31:0] i);
        rst_n     = r;
        pc_src_in = s;
        imm_in    = i;
        if (r) begin
            exp_pc = 32'h0;
        end else if (s == 2'd0) begin
            exp_pc = exp_pc + 32'd4;
        end else if (s == 2'd1) begin
            exp_pc = exp_pc + i;
        end else if (s == 2'd2) begin
            exp_pc = i & 32'hFFFF_FFFE;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        pc_src_in = 2'b00;
        imm_in    = 32'h0;
        exp_pc    = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (pc_out !== 32'h0) begin
                errors++;
                $display("FAIL reset_cycle%0d: pc_out=%h required=%h", k, pc_out, 32'h0);
            end
        end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        rst_n = 1'b0;
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL seq_start: pc_out=%h required=%h", pc_out, 32'h0);
        end
        for (int k = 1; k <= 3; k++) begin
            drive_cycle(1'b0, 2'b00, $urandom);
            want = 32'(4 * k);
            checks++;
            if (pc_out !== want) begin
                errors++;
                $display("FAIL seq_step%0d: pc_out=%h required=%h", k, pc_out, want);
            end
        end
    endtask

    task automatic test_branch();
        drive_cycle(1'b0, 2'b01, 32'hFFFF_FFF8);
        checks++;
        if (pc_out !== 32'd4) begin
            errors++;
            $display("FAIL branch_back: pc_out=%h required=%h", pc_out, 32'd4);
        end
        drive_cycle(1'b0, 2'b01, 32'd16);
        checks++;
        if (pc_out !== 32'd20) begin
            errors++;
            $display("FAIL branch_fwd: pc_out=%h required=%h", pc_out, 32'd20);
        end
    endtask

    task automatic test_jalr_hold();
        drive_cycle(1'b0, 2'b10, 32'h0000_1003);
        checks++;
        if (pc_out !== 32'h0000_1002) begin
            errors++;
            $display("FAIL jalr_bit0: pc_out=%h required=%h", pc_out, 32'h0000_1002);
        end
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1'b0, 2'b11, $urandom);
            checks++;
            if (pc_out !== 32'h0000_1002) begin
                errors++;
                $display("FAIL hold%0d: pc_out=%h required=%h", k, pc_out, 32'h0000_1002);
            end
        end
    endtask

    task automatic test_wrap();
        drive_cycle(1'b0, 2'b10, 32'hFFFF_FFFC);
        checks++;
        if (pc_out !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_jump: pc_out=%h required=%h", pc_out, 32'hFFFF_FFFC);
        end
        drive_cycle(1'b0, 2'b00, 32'h0);
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL wrap_plus4: pc_out=%h required=%h", pc_out, 32'h0);
        end
    endtask

    task automatic test_reset_override();
        drive_cycle(1'b0, 2'b10, 32'd40);
        checks++;
        if (pc_out !== 32'd40) begin
            errors++;
            $display("FAIL ovr_setup: pc_out=%h required=%h", pc_out, 32'd40);
        end
        drive_cycle(1'b1, 2'b01, 32'd100);
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL ovr_reset: pc_out=%h required=%h", pc_out, 32'h0);
        end
        drive_cycle(1'b0, 2'b00, 32'h0);
        checks++;
        if (pc_out !== 32'd4) begin
            errors++;
            $display("FAIL ovr_release: pc_out=%h required=%h", pc_out, 32'd4);
        end
    endtask

    task automatic test_random();
        logic        r;
        logic [1:0]  s;
        logic [31:0] i;
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 15) == 0);
            s = 2'($urandom_range(0, 3));
            i = $urandom;
            drive_cycle(r, s, i);
            checks++;
            if (pc_out !== exp_pc) begin
                errors++;
                $display("FAIL random%0d: src=%0d rst=%0b pc_out=%h required=%h", n, s, r, pc_out, exp_pc);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        pc_src_in = 2'b00;
        imm_in    = 32'h0;
        exp_pc    = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jalr_hold();
        test_wrap();
        test_reset_override();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
